// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared definitions for the bit-serial adder/subtractor: FSM state
//   encoding, operation select constants and the default operand width.
//   Optional feature macro used by the files of this block: SERIAL_ADDSUB_OVF_EN
//   (adds the signed-overflow output).
package serial_addsub_pkg;

   // Default operand/result width in bits (legal range 2..32).
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Operation select carried on the op input.
   localparam logic OP_SUB = 1'b0;
   localparam logic OP_ADD = 1'b1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Request/response bundle of the bit-serial adder/subtractor.
//   Parameter WIDTH : operand/result width.
//   Signals:
//     start  - request, sampled at a clk edge while the unit is accepting
//     op     - 0 = subtract (a-b), 1 = add (a+b)
//     a, b   - operands, sampled with start
//     busy   - high while an operation is running
//     done   - one-cycle pulse, result valid
//     result - difference/sum
//     cout   - final borrow (sub) or carry (add)
//     ovf    - signed overflow (only with SERIAL_ADDSUB_OVF_EN defined)
//   Modports: master drives the request, slave is the arithmetic unit.
interface serial_addsub_if #(
   parameter int unsigned WIDTH = serial_addsub_pkg::DEFAULT_WIDTH
) ();

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, op, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
      input  ovf,
`endif
      input  busy, done, result, cout
   );

   modport slave (
      input  start, op, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
      output ovf,
`endif
      output busy, done, result, cout
   );

endinterface

// File: rtl/addsub_cell_1bit.sv
// addsub_cell_1bit
//   One-bit combinational add/subtract cell used serially by serial_addsub.
//   Ports:
//     i_a, i_b  - operand bits
//     i_cin     - incoming carry (add) or borrow (sub)
//     i_op      - OP_SUB / OP_ADD
//     o_s       - sum or difference bit
//     o_cout    - outgoing carry (add) or borrow (sub)
module addsub_cell_1bit
   import serial_addsub_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   input  logic i_op,
   output logic o_s,
   output logic o_cout
);

   logic w_p;

   // Sum and difference bits are the same XOR; only the carry/borrow differs.
   assign w_p = i_a ^ i_b;
   assign o_s = w_p ^ i_cin;

   always_comb begin
      o_cout = 1'b0;
      unique case (i_op)
         OP_ADD: o_cout = (i_a & i_b) | (i_cin & w_p);
         OP_SUB: o_cout = (~i_a & i_b) | (~w_p & i_cin);
         default: o_cout = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder/subtractor. One bit per clock, LSB first, through a
//   single addsub_cell_1bit. An accepted start latches the operands; WIDTH
//   RUN cycles follow, then one DONE cycle with done=1.
//   Optional feature: define SERIAL_ADDSUB_OVF_EN to add the ovf output
//   (carry into MSB XOR carry/borrow out of MSB).
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - serial_addsub_if.slave (start/op/a/b in; busy/done/result/cout/ovf out)
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_addsub_if.slave bus
);

   localparam int unsigned  CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e            r_state;
   state_e            w_state_d;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_op;
   logic [CntW-1:0]   r_cnt;
   logic              r_carry;
   logic [WIDTH-1:0]  r_result;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic              r_ovf;
`endif

   logic              w_accept;
   logic              w_step;
   logic              w_last;
   logic              w_sum;
   logic              w_cout;

   addsub_cell_1bit u_cell (
      .i_a    (r_a[r_cnt]),
      .i_b    (r_b[r_cnt]),
      .i_cin  (r_carry),
      .i_op   (r_op),
      .o_s    (w_sum),
      .o_cout (w_cout)
   );

   // Next-state logic. A start in DONE is accepted directly so back-to-back
   // operations run every WIDTH+1 cycles.
   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_step    = 1'b0;
      w_last    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_accept  = 1'b1;
               w_state_d = StRun;
            end
         end
         StRun: begin
            w_step = 1'b1;
            if (r_cnt == LastCnt) begin
               w_last    = 1'b1;
               w_state_d = StDone;
            end
         end
         StDone: begin
            if (bus.start) begin
               w_accept  = 1'b1;
               w_state_d = StRun;
            end else begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 1'b0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_op    <= bus.op;
         r_cnt   <= '0;
         r_carry <= 1'b0;
      end else if (w_step) begin
         r_result[r_cnt] <= w_sum;
         r_carry         <= w_cout;
         r_cnt           <= r_cnt + CntW'(1);
`ifdef SERIAL_ADDSUB_OVF_EN
         // At the MSB, r_carry is the carry/borrow into that bit.
         if (w_last) begin
            r_ovf <= r_carry ^ w_cout;
         end
`endif
      end
   end

   assign bus.busy   = (r_state == StRun);
   assign bus.done   = (r_state == StDone);
   assign bus.result = r_result;
   assign bus.cout   = r_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign bus.ovf    = r_ovf;
`endif

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low; one clock only.
REQ-004 SHALL have port start  input  1  request; sampled at a clk edge while the unit is accepting.
REQ-005 SHALL have port op  input  1  0 = subtract (a-b), 1 = add (a+b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  minuend/augend; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  subtrahend/addend; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port result  output  WIDTH  difference/sum.
REQ-011 SHALL have port cout  output  1  final borrow (op=0) or carry (op=1).
REQ-012 SHALL have port ovf  output  1  signed overflow; present only when SERIAL_ADDSUB_OVF_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a, b, op, clear the bit counter and the carry/borrow register to 0, and go to RUN.
REQ-015 RUN: each edge SHALL process one bit, LSB first, through one 1-bit cell: sub d=a^b^bin, bout=(~a&b)|(~(a^b)&bin); add s=a^b^cin, co=(a&b)|(cin&(a^b)).
REQ-016 Result bit i SHALL be written at the (i+1)-th edge after start is sampled; after WIDTH bits the FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, result and cout final; then IDLE (or RUN if start=1 in that cycle).
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th edge after start sampling; throughput one op per WIDTH+1 cycles.
REQ-019 busy SHALL be 1 in RUN only; start while busy SHALL be ignored with no effect on the operation in progress.
REQ-020 result, cout (and ovf) SHALL hold their last final value from DONE until the next accepted start; they may change during RUN.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; a-b with a<b SHALL give the two's-complement wrap and cout=1.
REQ-022 op, a, b changes while busy SHALL not affect the latched operands.

Reset
REQ-023 rst_n=0 SHALL force IDLE asynchronously with busy=0, done=0, result=0, cout=0, ovf=0, counter=0 and carry/borrow register=0.
REQ-024 Reset during RUN SHALL abort the operation; no done pulse SHALL follow and the first start after release SHALL be accepted normally.

Configuration
REQ-025 With SERIAL_ADDSUB_OVF_EN defined, ovf SHALL equal carry-into-MSB XOR carry/borrow-out-of-MSB, captured at the final bit; it holds with result.
REQ-026 Without SERIAL_ADDSUB_OVF_EN, port ovf and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Package serial_addsub_pkg SHALL hold the FSM state encoding, the OP_SUB=0/OP_ADD=1 constants and the default WIDTH.
REQ-028 The 1-bit combinational cell SHALL be sub-module addsub_cell_1bit (a, b, cin, op -> s, cout), instantiated once.

Verification
REQ-029 op=0, a=0x05, b=0x03, start one cycle -> busy 8 cycles, done pulse, result=0x02, cout=0.
REQ-030 op=0, a=0x03, b=0x05 -> result=0xFE, cout=1; with OVF_EN a=0x80, b=0x01 -> result=0x7F, ovf=1.
REQ-031 op=1, a=0xFF, b=0x01 -> result=0x00, cout=1; with OVF_EN a=0x7F, b=0x01 -> result=0x80, ovf=1.
REQ-032 start=1 with a=0x10 at the 3rd RUN cycle of op (0x05-0x03) -> ignored; result=0x02, exactly one done.
REQ-033 rst_n low at the 4th RUN cycle -> outputs 0 immediately, no done; next op 0x0A+0x05 -> result=0x0F, cout=0.
REQ-034 start held high continuously with op=1, a=0x01, b=0x01 -> done every 9 cycles, result=0x02 each time.
